// File: rtl/whack_pkg.sv
// whack_pkg: shared state encoding and arithmetic helpers for the whack-a-mole controller
package whack_pkg;
  typedef enum logic [1:0] {IDLE, ARM, PLAY, OVER} state_t;
  localparam int MAX_LEVEL = 6;
  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) c = c + {3'b0, v[i]};
    return c;
  endfunction
  function automatic logic [26:0] reload_of(input int clk_hz, input int lvl);
    return 27'(clk_hz / (lvl + 1) - 1);
  endfunction
  // thresholds sit at 2*step, 3*step, ... so level 0 covers the first two steps
  function automatic logic [2:0] level_of(input logic [7:0] score, input int step);
    int q;
    q = int'(score) / step;
    return q < 2 ? 3'd0 : q > MAX_LEVEL + 1 ? 3'(MAX_LEVEL) : 3'(q - 1);
  endfunction
endpackage

// File: rtl/whack_game_ctrl_if.sv
// whack_game_ctrl_if: player I/O, LFSR and display signals of the game controller
interface whack_game_ctrl_if;
  logic       start;
  logic [7:0] sw;
  logic [7:0] mole;
  logic       mole_step;
  logic [7:0] led;
  logic [7:0] score;
  logic [2:0] level;
  logic [3:0] misses;
  logic       playing;
  logic       game_over;
  modport master (output start, sw, mole, input mole_step, led, score, level, misses, playing, game_over);
  modport slave (input start, sw, mole, output mole_step, led, score, level, misses, playing, game_over);
endinterface

// File: rtl/rate_tick_gen.sv
// rate_tick_gen: down-counter emitting a one-cycle tick at zero, reloading synchronously
module rate_tick_gen (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [26:0] reload,
  output logic        tick
);
  logic [26:0] cnt;
  assign tick = en && cnt == '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= (!en || tick) ? reload : cnt - 27'd1;
endmodule

// File: rtl/whack_game_ctrl.sv
// whack_game_ctrl: round/level sequencer, hit scoring and miss counting for whack-a-mole
module whack_game_ctrl
  import whack_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int NUM_MOLES  = 8,
  parameter int LEVEL_STEP = 10,
  parameter int MAX_MISSES = 8
) (
  input logic clk,
  input logic rst_n,
  whack_game_ctrl_if.slave bus
);
  localparam logic [26:0] RELOAD [8] = '{
    reload_of(CLK_HZ, 0), reload_of(CLK_HZ, 1), reload_of(CLK_HZ, 2), reload_of(CLK_HZ, 3),
    reload_of(CLK_HZ, 4), reload_of(CLK_HZ, 5), reload_of(CLK_HZ, 6), reload_of(CLK_HZ, 6)};
  state_t state, state_nxt;
  logic start_q, start_rise, tick, over, mole_step;
  logic [NUM_MOLES-1:0] sw_s1, sw_s2, sw_q, hit_mask, led, hits;
  logic [7:0] score, score_sat;
  logic [8:0] score_add;
  logic [3:0] misses, miss_sat;
  logic [4:0] miss_add;
  logic [2:0] level, next_level;
  assign start_rise = bus.start & ~start_q;
  assign hits       = sw_s2 & ~sw_q & led & ~hit_mask;
  assign score_add  = {1'b0, score} + {5'b0, popcount8(hits)};
  assign score_sat  = score_add[8] ? 8'hFF : score_add[7:0];
  // a hit landing on the tick cycle belongs to the closing window, so it is not a miss
  assign miss_add   = {1'b0, misses} + {1'b0, popcount8(led & ~(hit_mask | hits))};
  assign miss_sat   = miss_add[4] ? 4'hF : miss_add[3:0];
  assign over       = miss_sat >= 4'(MAX_MISSES);
  assign next_level = level_of(score, LEVEL_STEP);
  // reload at a tick must already use the level that the tick installs
  rate_tick_gen u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state == PLAY),
    .reload(RELOAD[state == PLAY ? next_level : 3'd0]),
    .tick  (tick)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    mole_step = 1'b0;
    case (state)
      IDLE: state_nxt = start_rise ? ARM : IDLE;
      ARM: begin
        state_nxt = PLAY;
        mole_step = 1'b1;
      end
      PLAY: begin
        state_nxt = start_rise ? ARM : tick && over ? OVER : PLAY;
        mole_step = !start_rise && tick && !over;
      end
      default: state_nxt = start_rise ? ARM : OVER;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      start_q  <= 1'b0;
      sw_s1    <= '0;
      sw_s2    <= '0;
      sw_q     <= '0;
      hit_mask <= '0;
      led      <= '0;
      score    <= '0;
      misses   <= '0;
      level    <= '0;
    end else begin
      start_q <= bus.start;
      sw_s1   <= bus.sw;
      sw_s2   <= sw_s1;
      sw_q    <= sw_s2;
      if (state == ARM) begin
        hit_mask <= '0;
        led      <= '0;
        score    <= '0;
        misses   <= '0;
        level    <= '0;
      end else if (state == PLAY && !start_rise) begin
        score    <= score_sat;
        hit_mask <= tick ? '0 : hit_mask | hits;
        if (tick) begin
          misses <= miss_sat;
          led    <= over ? '0 : bus.mole;
          if (!over) level <= next_level;
        end
      end
    end
  assign bus.mole_step = mole_step;
  assign bus.led       = led;
  assign bus.score     = score;
  assign bus.level     = level;
  assign bus.misses    = misses;
  assign bus.playing   = state == PLAY;
  assign bus.game_over = state == OVER;
endmodule

// File: tb/tb_whack_game_ctrl.sv
// tb_whack_game_ctrl: directed scenarios checked against a window-level game model every cycle
module tb_whack_game_ctrl;
  localparam int HZ = 100;
  localparam int MAXM = 8;
  localparam int S_IDLE = 0, S_ARM = 1, S_PLAY = 2, S_OVER = 3;
  logic clk = 1'b0, rst_n = 1'b0;
  int tests = 0, fails = 0;
  bit run = 1'b0;
  whack_game_ctrl_if bus ();
  whack_game_ctrl #(.CLK_HZ(HZ)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  int m_st, m_age, m_period, m_score, m_miss, m_level;
  logic [7:0] m_led, m_hit, m_d1, m_d2, m_d3;
  logic m_sp;

  function automatic int lvl(input int s);
    int l;
    if (s < 20) return 0;
    l = s / 10 - 1;
    return l > 6 ? 6 : l;
  endfunction
  function automatic int cap(input int v, input int m);
    return v > m ? m : v;
  endfunction
  function automatic logic [7:0] cur_hits();
    return (m_d2 & ~m_d3) & m_led & ~m_hit;
  endfunction
  function automatic bit exp_step();
    if (m_st == S_ARM) return 1'b1;
    if (m_st != S_PLAY || (bus.start && !m_sp) || m_age != m_period - 1) return 1'b0;
    return cap(m_miss + $countones(m_led & ~(m_hit | cur_hits())), 15) < MAXM;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    logic [7:0] hits;
    int sc, ms;
    bit srise;
    if (!rst_n) begin
      m_st <= S_IDLE; m_age <= 0; m_period <= HZ; m_score <= 0; m_miss <= 0; m_level <= 0;
      m_led <= '0; m_hit <= '0; m_d1 <= '0; m_d2 <= '0; m_d3 <= '0; m_sp <= 1'b0;
    end else begin
      srise = bus.start && !m_sp;
      hits = cur_hits();
      m_d1 <= bus.sw; m_d2 <= m_d1; m_d3 <= m_d2; m_sp <= bus.start;
      case (m_st)
        S_ARM: begin
          m_score <= 0; m_miss <= 0; m_level <= 0; m_hit <= '0; m_led <= '0;
          m_age <= 0; m_period <= HZ; m_st <= S_PLAY;
        end
        S_PLAY:
          if (srise) m_st <= S_ARM;
          else begin
            sc = cap(m_score + $countones(hits), 255);
            m_score <= sc;
            if (m_age == m_period - 1) begin
              ms = cap(m_miss + $countones(m_led & ~(m_hit | hits)), 15);
              m_miss <= ms; m_hit <= '0; m_age <= 0;
              if (ms >= MAXM) begin
                m_st <= S_OVER; m_led <= '0;
              end else begin
                m_led <= bus.mole; m_level <= lvl(m_score); m_period <= HZ / (lvl(m_score) + 1);
              end
            end else begin
              m_hit <= m_hit | hits; m_age <= m_age + 1;
            end
          end
        default: if (srise) m_st <= S_ARM;
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [25:0] dut_out();
    return {bus.mole_step, bus.led, bus.score, bus.level, bus.misses, bus.playing, bus.game_over};
  endfunction

  always @(negedge clk)
    if (run && rst_n)
      check("cycle", 32'(dut_out()),
            32'({exp_step(), m_led, 8'(m_score), 3'(m_level), 4'(m_miss), m_st == S_PLAY, m_st == S_OVER}));

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic to_tick();
    for (int i = 0; i < 300; i++) begin
      if (m_st == S_PLAY && m_age == m_period - 1) return;
      cyc(1);
    end
    check("to_tick timeout", 0, 1);
  endtask
  task automatic hit(input logic [7:0] v);
    bus.sw = v;
    cyc(3);
    bus.sw = '0;
    cyc(3);
  endtask
  task automatic restart();
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
    cyc(1);
  endtask

  initial begin
    bus.start = 1'b0; bus.sw = '0; bus.mole = 8'h81;
    #3 check("reset outputs", 32'(dut_out()), 0);
    cyc(2);
    rst_n = 1'b1;
    run = 1'b1;
    cyc(2);
    bus.start = 1'b1;
    cyc(1);
    check("arm step", bus.mole_step, 1);
    check("arm playing", bus.playing, 0);
    bus.start = 1'b0;
    cyc(1);
    check("play entered", bus.playing, 1);
    cyc(99);
    check("first tick at 100", bus.mole_step, 1);
    cyc(1);
    check("led 81", bus.led, 8'h81);
    bus.mole = 8'hFF;
    hit(8'h01);
    hit(8'h01);
    check("one point per mole", bus.score, 1);
    to_tick(); cyc(1);
    check("sw7 missed", bus.misses, 1);
    hit(8'hFF);
    check("score 9", bus.score, 9);
    to_tick(); cyc(1);
    hit(8'hFF);
    check("score 17", bus.score, 17);
    bus.mole = 8'h07;
    to_tick(); cyc(1);
    hit(8'h03);
    hit(8'h04);
    check("score 20", bus.score, 20);
    check("level held mid-window", bus.level, 0);
    bus.mole = 8'h01;
    to_tick(); cyc(1);
    check("level 1 at tick", bus.level, 1);
    cyc(47);
    bus.sw = 8'h01;
    cyc(2);
    check("tick interval 50", bus.mole_step, 1);
    cyc(1);
    bus.sw = '0;
    check("hit on tick score", bus.score, 21);
    check("hit on tick misses", bus.misses, 1);
    check("hit on tick led", bus.led, 8'h01);
    for (int i = 0; i < 7; i++) begin
      to_tick();
      if (i == 6) check("no step at over", bus.mole_step, 0);
      cyc(1);
    end
    check("misses 8", bus.misses, 8);
    check("game_over", bus.game_over, 1);
    check("over led", bus.led, 0);
    restart();
    check("restart playing", bus.playing, 1);
    check("restart score", bus.score, 0);
    check("restart misses", bus.misses, 0);
    bus.start = 1'b1;
    cyc(1);
    check("abort to arm", bus.playing, 0);
    cyc(5);
    check("held start no retrigger", bus.playing, 1);
    bus.start = 1'b0;
    bus.mole = 8'hFF;
    to_tick(); cyc(1);
    repeat (5) begin
      hit(8'hFF);
      to_tick(); cyc(1);
    end
    hit(8'h1F);
    check("score 45", bus.score, 45);
    check("level 3", bus.level, 3);
    #2 rst_n = 1'b0;
    #1 check("async reset outputs", 32'(dut_out()), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1);
    restart();
    to_tick(); cyc(1);
    repeat (33) begin
      hit(8'hFF);
      to_tick(); cyc(1);
    end
    check("score saturates", bus.score, 255);
    check("level caps", bus.level, 6);
    run = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
